// File: rtl/conv_layer_mem.sv
// conv_layer_mem
//   Layer-memory responder on the far end of the CONV result interface.
//   Holds the Layer 0 bank (convolution output) and the Layer 1 bank
//   (max-pool output), serves CONV writes/reads selected by csel, and
//   streams either bank back to the host over a valid/ready port once
//   CONV has dropped busy.
//
// Optional feature macro: CONV_LAYER_MEM_RAW_BYPASS_EN
//   Defined   : a same-cycle cwr/crd to the same bank and address returns
//               the word being written (new data).
//   Undefined : that case returns the word stored before the write.
//
// Ports
//   clk, reset           single rising-edge clock, async active-low reset
//   busy                 CONV frame-in-progress; its rising edge starts a frame
//   cwr/caddr_wr/cdata_wr  CONV write strobe, address, data
//   crd/caddr_rd         CONV read strobe, address
//   csel                 bank select: 3'b001 = L0, 3'b011 = L1
//   cdata_rd             registered CONV read data
//   wr_seen              sticky per-bank written-this-frame flags (bit0 = L0)
//   bad_sel              sticky illegal-select / out-of-range flag
//   dump_req, dump_bank  readback start pulse and bank (0 = L0, 1 = L1)
//   dump_valid/ready     readback handshake
//   dump_addr/dump_data  address and data of the presented readback word
//   dump_done            pulse after the last readback word transfers
//   dump_abort           pulse when a new frame cancels a readback

module conv_layer_mem #(
  parameter int DW       = 20,
  parameter int AW       = 12,
  parameter int L0_DEPTH = 4096,
  parameter int L1_DEPTH = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          busy,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  input  logic [2:0]    csel,
  output logic [DW-1:0] cdata_rd,
  output logic [1:0]    wr_seen,
  output logic          bad_sel,
  input  logic          dump_req,
  input  logic          dump_bank,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          dump_done,
  output logic          dump_abort
);

  localparam int L0_IW = $clog2(L0_DEPTH);
  localparam int L1_IW = $clog2(L1_DEPTH);

  localparam logic [2:0] SEL_L0 = 3'b001;
  localparam logic [2:0] SEL_L1 = 3'b011;

  localparam logic [AW:0]   L0_DEPTH_W = (AW+1)'(L0_DEPTH);
  localparam logic [AW:0]   L1_DEPTH_W = (AW+1)'(L1_DEPTH);
  localparam logic [AW-1:0] L0_LAST    = AW'(L0_DEPTH - 1);
  localparam logic [AW-1:0] L1_LAST    = AW'(L1_DEPTH - 1);

  typedef enum logic {
    DUMP_IDLE,
    DUMP_STREAM
  } dump_state_t;

  logic [DW-1:0] l0_mem [L0_DEPTH];
  logic [DW-1:0] l1_mem [L1_DEPTH];

  // CONV-side decode
  logic          wr_ok_l0, wr_ok_l1, rd_ok_l0, rd_ok_l1;
  logic          l0_we, l1_we, access_bad, busy_rise;

  logic          busy_q;
  logic [DW-1:0] cdata_rd_q, cdata_rd_d;
  logic [1:0]    wr_seen_q, wr_seen_d;
  logic          bad_sel_q, bad_sel_d;

  // Readback path: a prefetch stage feeding the presented output word
  dump_state_t   state_q, state_d;
  logic          bank_q, bank_d;
  logic [AW:0]   fetch_cnt_q, fetch_cnt_d;
  logic          pf_valid_q, pf_valid_d;
  logic [DW-1:0] pf_data_q, pf_data_d;
  logic [AW-1:0] pf_addr_q, pf_addr_d;
  logic          dump_valid_q, dump_valid_d;
  logic [DW-1:0] dump_data_q, dump_data_d;
  logic [AW-1:0] dump_addr_q, dump_addr_d;
  logic          dump_done_q, dump_done_d;
  logic          dump_abort_q, dump_abort_d;

  logic [AW:0]   depth_w;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] fetch_data;
  logic          xfer, out_load, fetch;

  // Address/bank legality for both CONV strobes; anything not a legal
  // access to L0 or L1 is flagged and has no effect on memory.
  always_comb begin
    wr_ok_l0   = (csel == SEL_L0) && ({1'b0, caddr_wr} < L0_DEPTH_W);
    wr_ok_l1   = (csel == SEL_L1) && ({1'b0, caddr_wr} < L1_DEPTH_W);
    rd_ok_l0   = (csel == SEL_L0) && ({1'b0, caddr_rd} < L0_DEPTH_W);
    rd_ok_l1   = (csel == SEL_L1) && ({1'b0, caddr_rd} < L1_DEPTH_W);
    l0_we      = cwr && wr_ok_l0;
    l1_we      = cwr && wr_ok_l1;
    access_bad = (cwr && !(wr_ok_l0 || wr_ok_l1)) ||
                 (crd && !(rd_ok_l0 || rd_ok_l1));
    busy_rise  = busy && !busy_q;
  end

  // Memory contents are never reset or cleared.
  always_ff @(posedge clk) begin
    if (l0_we) l0_mem[caddr_wr[L0_IW-1:0]] <= cdata_wr;
    if (l1_we) l1_mem[caddr_wr[L1_IW-1:0]] <= cdata_wr;
  end

  // CONV read data and frame flags. The array is read before the write of
  // the same edge lands, so a colliding read naturally sees the old word.
  always_comb begin
    cdata_rd_d = cdata_rd_q;
    if (crd) begin
      cdata_rd_d = '0;
      if (rd_ok_l0)      cdata_rd_d = l0_mem[caddr_rd[L0_IW-1:0]];
      else if (rd_ok_l1) cdata_rd_d = l1_mem[caddr_rd[L1_IW-1:0]];
`ifdef CONV_LAYER_MEM_RAW_BYPASS_EN
      if ((rd_ok_l0 || rd_ok_l1) && cwr && (caddr_wr == caddr_rd))
        cdata_rd_d = cdata_wr;
`endif
    end
    // A new frame clears history; events in the same cycle still register.
    wr_seen_d = (busy_rise ? 2'b00 : wr_seen_q) | {l1_we, l0_we};
    bad_sel_d = (busy_rise ? 1'b0 : bad_sel_q) | access_bad;
  end

  // Readback FSM. The prefetch register keeps one word in flight so the
  // combinational array read never sits on the output path and a word can
  // be presented every cycle under continuous ready.
  always_comb begin
    depth_w    = bank_q ? L1_DEPTH_W : L0_DEPTH_W;
    last_addr  = bank_q ? L1_LAST : L0_LAST;
    fetch_data = bank_q ? l1_mem[fetch_cnt_q[L1_IW-1:0]]
                        : l0_mem[fetch_cnt_q[L0_IW-1:0]];
    xfer       = dump_valid_q && dump_ready;
    out_load   = pf_valid_q && (!dump_valid_q || xfer);
    fetch      = (state_q == DUMP_STREAM) && !busy &&
                 (fetch_cnt_q < depth_w) && (!pf_valid_q || out_load);

    state_d      = state_q;
    bank_d       = bank_q;
    fetch_cnt_d  = fetch_cnt_q;
    pf_valid_d   = pf_valid_q;
    pf_data_d    = pf_data_q;
    pf_addr_d    = pf_addr_q;
    dump_valid_d = dump_valid_q;
    dump_data_d  = dump_data_q;
    dump_addr_d  = dump_addr_q;
    dump_done_d  = 1'b0;
    dump_abort_d = 1'b0;

    case (state_q)
      DUMP_IDLE: begin
        if (dump_req && !busy) begin
          state_d      = DUMP_STREAM;
          bank_d       = dump_bank;
          fetch_cnt_d  = '0;
          pf_valid_d   = 1'b0;
          dump_valid_d = 1'b0;
          dump_addr_d  = '0;
        end
      end
      DUMP_STREAM: begin
        if (busy_rise) begin
          state_d      = DUMP_IDLE;
          pf_valid_d   = 1'b0;
          dump_valid_d = 1'b0;
          dump_abort_d = 1'b1;
        end else if (xfer && (dump_addr_q == last_addr)) begin
          state_d      = DUMP_IDLE;
          pf_valid_d   = 1'b0;
          dump_valid_d = 1'b0;
          dump_done_d  = 1'b1;
        end else begin
          if (fetch) begin
            pf_valid_d  = 1'b1;
            pf_data_d   = fetch_data;
            pf_addr_d   = fetch_cnt_q[AW-1:0];
            fetch_cnt_d = fetch_cnt_q + (AW+1)'(1);
          end else if (out_load) begin
            pf_valid_d  = 1'b0;
          end
          if (out_load) begin
            dump_valid_d = 1'b1;
            dump_data_d  = pf_data_q;
            dump_addr_d  = pf_addr_q;
          end else if (xfer) begin
            dump_valid_d = 1'b0;
          end
        end
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  // All control and output registers; reset also drops any stream silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q       <= 1'b0;
      cdata_rd_q   <= '0;
      wr_seen_q    <= '0;
      bad_sel_q    <= 1'b0;
      state_q      <= DUMP_IDLE;
      bank_q       <= 1'b0;
      fetch_cnt_q  <= '0;
      pf_valid_q   <= 1'b0;
      pf_data_q    <= '0;
      pf_addr_q    <= '0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
      dump_addr_q  <= '0;
      dump_done_q  <= 1'b0;
      dump_abort_q <= 1'b0;
    end else begin
      busy_q       <= busy;
      cdata_rd_q   <= cdata_rd_d;
      wr_seen_q    <= wr_seen_d;
      bad_sel_q    <= bad_sel_d;
      state_q      <= state_d;
      bank_q       <= bank_d;
      fetch_cnt_q  <= fetch_cnt_d;
      pf_valid_q   <= pf_valid_d;
      pf_data_q    <= pf_data_d;
      pf_addr_q    <= pf_addr_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
      dump_addr_q  <= dump_addr_d;
      dump_done_q  <= dump_done_d;
      dump_abort_q <= dump_abort_d;
    end
  end

  assign cdata_rd   = cdata_rd_q;
  assign wr_seen    = wr_seen_q;
  assign bad_sel    = bad_sel_q;
  assign dump_valid = dump_valid_q;
  assign dump_data  = dump_data_q;
  assign dump_addr  = dump_addr_q;
  assign dump_done  = dump_done_q;
  assign dump_abort = dump_abort_q;

endmodule
